// File: rtl/hdmi_pkg.sv
// Shared HDMI video timing types and the runtime-selectable mode table.
package hdmi_pkg;

    typedef logic [11:0] bus12_t;

    typedef struct packed {
        bus12_t hframe;
        bus12_t hscreen;
        bus12_t hsync_start;
        bus12_t hsync_end;
        bit     hpol;
        bus12_t vframe;
        bus12_t vscreen;
        bus12_t vsync_start;
        bus12_t vsync_end;
        bit     vpol;
    } vtiming_t;

    typedef enum logic [1:0] {
        VM_720P60    = 2'd0,
        VM_1080P30   = 2'd1,
        VM_1080P60RB = 2'd2
    } vmode_t;

    localparam int NUM_VMODES = 3;

    // Sync fields are [start, end) positions; pol=1 means the sync pulse is driven high.
    localparam vtiming_t VTIMING [NUM_VMODES] = '{
        '{12'd1650, 12'd1280, 12'd1390, 12'd1430, 1'b1, 12'd750,  12'd720,  12'd725,  12'd730,  1'b1},
        '{12'd2200, 12'd1920, 12'd2008, 12'd2052, 1'b1, 12'd1125, 12'd1080, 12'd1084, 12'd1089, 1'b1},
        '{12'd2000, 12'd1920, 12'd1928, 12'd1960, 1'b1, 12'd1111, 12'd1080, 12'd1097, 12'd1105, 1'b0}
    };

    function automatic vtiming_t mode_timing(input logic [1:0] mode);
        case (mode)
            VM_1080P30:   return VTIMING[1];
            VM_1080P60RB: return VTIMING[2];
            default:      return VTIMING[0];
        endcase
    endfunction

    function automatic bus12_t mode_hscreen(input logic [1:0] mode);
        case (mode)
            VM_1080P30:   return VTIMING[1].hscreen;
            VM_1080P60RB: return VTIMING[2].hscreen;
            default:      return VTIMING[0].hscreen;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_timing_lookahead.sv
// Early DE for the pixel fetch pipeline: DE of the position LOOKAHEAD pixels ahead,
// using the pending mode's geometry once the lookahead crosses into the next frame.
module hdmi_timing_lookahead
    import hdmi_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int LOOKAHEAD = 2
) (
    input  logic [CNT_W-1:0] hcnt,
    input  logic [CNT_W-1:0] vcnt,
    input  bus12_t           hframe,
    input  bus12_t           hscreen,
    input  bus12_t           vframe,
    input  bus12_t           vscreen,
    input  bus12_t           hscreen_pend,
    output logic             de_la
);

    logic [CNT_W:0] x_sum, x_wrap, y_cur, y_next;
    logic [CNT_W:0] hframe_w, hscreen_w, vframe_w, vscreen_w, hscreen_pend_w;

    // One extra bit keeps hcnt+LOOKAHEAD from overflowing before the modulo-HFRAME reduction.
    always_comb begin
        hframe_w       = (CNT_W+1)'(hframe);
        hscreen_w      = (CNT_W+1)'(hscreen);
        vframe_w       = (CNT_W+1)'(vframe);
        vscreen_w      = (CNT_W+1)'(vscreen);
        hscreen_pend_w = (CNT_W+1)'(hscreen_pend);
        y_cur          = {1'b0, vcnt};
        x_sum          = {1'b0, hcnt} + (CNT_W+1)'(LOOKAHEAD);
        x_wrap         = x_sum - hframe_w;
        y_next         = y_cur + (CNT_W+1)'(1);
        if (x_sum < hframe_w) begin
            de_la = (x_sum < hscreen_w) && (y_cur < vscreen_w);
        end else if (y_next < vframe_w) begin
            de_la = (x_wrap < hscreen_w) && (y_next < vscreen_w);
        end else begin
            de_la = x_wrap < hscreen_pend_w;
        end
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Runtime-selectable HDMI video timing generator. Requested modes are staged in a
// pending register and only take over at the frame wrap, so no frame is ever torn.
module hdmi_timing_gen
    import hdmi_pkg::*;
#(
    parameter int NUM_MODES    = 3,
    parameter int DEFAULT_MODE = 0,
    parameter int CNT_W        = 12,
    parameter int LOOKAHEAD    = 2,
    parameter int VS_ALIGN_HS  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode_sel,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             de,
    output logic             de_early,
    output logic             hsync,
    output logic             vsync,
    output logic             sof,
    output logic             eol,
    output logic [1:0]       mode_act,
    output logic             mode_err
);

    localparam vtiming_t DEF_GEO = VTIMING[DEFAULT_MODE];
    localparam bit       ALIGN   = (VS_ALIGN_HS != 0);

    vtiming_t         geo, geo_nxt;
    logic [1:0]       pending, pending_nxt, mode_act_nxt;
    logic             sel_ok, h_last, v_last, wrap;
    logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt;
    logic             de_nxt, de_la, hs_act, vs_on, vs_off, vs_act, sof_nxt, eol_nxt;
    bus12_t           pend_hscreen;

    always_comb begin
        sel_ok       = int'(mode_sel) < NUM_MODES;
        pending_nxt  = sel_ok ? mode_sel : pending;
        pend_hscreen = mode_hscreen(pending_nxt);
        h_last       = hcnt == CNT_W'(geo.hframe - 12'd1);
        v_last       = vcnt == CNT_W'(geo.vframe - 12'd1);
        wrap         = h_last && v_last;
        hcnt_nxt     = h_last ? '0 : hcnt + CNT_W'(1);
        vcnt_nxt     = vcnt;
        if (h_last) begin
            vcnt_nxt = v_last ? '0 : vcnt + CNT_W'(1);
        end
        mode_act_nxt = wrap ? pending : mode_act;
        geo_nxt      = wrap ? mode_timing(pending) : geo;
    end

    // Outputs are decoded from the next position so they register in step with the counters.
    always_comb begin
        de_nxt  = (hcnt_nxt < CNT_W'(geo_nxt.hscreen)) && (vcnt_nxt < CNT_W'(geo_nxt.vscreen));
        hs_act  = (hcnt_nxt >= CNT_W'(geo_nxt.hsync_start)) && (hcnt_nxt < CNT_W'(geo_nxt.hsync_end));
        vs_on   = (vcnt_nxt > CNT_W'(geo_nxt.vsync_start)) ||
                  ((vcnt_nxt == CNT_W'(geo_nxt.vsync_start)) &&
                   (!ALIGN || (hcnt_nxt >= CNT_W'(geo_nxt.hsync_start))));
        vs_off  = (vcnt_nxt > CNT_W'(geo_nxt.vsync_end)) ||
                  ((vcnt_nxt == CNT_W'(geo_nxt.vsync_end)) &&
                   (!ALIGN || (hcnt_nxt >= CNT_W'(geo_nxt.hsync_start))));
        vs_act  = vs_on && !vs_off;
        sof_nxt = (hcnt_nxt == '0) && (vcnt_nxt == '0);
        eol_nxt = (hcnt_nxt == CNT_W'(geo_nxt.hscreen - 12'd1)) &&
                  (vcnt_nxt < CNT_W'(geo_nxt.vscreen));
    end

    hdmi_timing_lookahead #(
        .CNT_W     (CNT_W),
        .LOOKAHEAD (LOOKAHEAD)
    ) u_lookahead (
        .hcnt         (hcnt_nxt),
        .vcnt         (vcnt_nxt),
        .hframe       (geo_nxt.hframe),
        .hscreen      (geo_nxt.hscreen),
        .vframe       (geo_nxt.vframe),
        .vscreen      (geo_nxt.vscreen),
        .hscreen_pend (pend_hscreen),
        .de_la        (de_la)
    );

    // Reset parks the counters on the last pixel so the first enabled edge wraps to (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= CNT_W'(DEF_GEO.hframe - 12'd1);
            vcnt     <= CNT_W'(DEF_GEO.vframe - 12'd1);
            geo      <= DEF_GEO;
            pending  <= 2'(DEFAULT_MODE);
            mode_act <= 2'(DEFAULT_MODE);
            mode_err <= 1'b0;
            de       <= 1'b0;
            de_early <= 1'b0;
            hsync    <= !DEF_GEO.hpol;
            vsync    <= !DEF_GEO.vpol;
            sof      <= 1'b0;
            eol      <= 1'b0;
        end else if (en) begin
            hcnt     <= hcnt_nxt;
            vcnt     <= vcnt_nxt;
            geo      <= geo_nxt;
            pending  <= pending_nxt;
            mode_act <= mode_act_nxt;
            if (!sel_ok) begin
                mode_err <= 1'b1;
            end
            de       <= de_nxt;
            de_early <= de_la;
            hsync    <= geo_nxt.hpol ? hs_act : !hs_act;
            vsync    <= geo_nxt.vpol ? vs_act : !vs_act;
            sof      <= sof_nxt;
            eol      <= eol_nxt;
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Scoreboard bench for hdmi_timing_gen: a stimulus process pushes model-predicted
// outputs per clock, a monitor pops and compares them after every rising edge.
module tb_hdmi_timing_gen;

    localparam int LA = 2;

    // Hand-entered mode geometry: 720p60, 1080p30, 1080p60 CVT-RBv2.
    localparam int HF  [3] = '{1650, 2200, 2000};
    localparam int HS  [3] = '{1280, 1920, 1920};
    localparam int HSS [3] = '{1390, 2008, 1928};
    localparam int HSE [3] = '{1430, 2052, 1960};
    localparam int HP  [3] = '{1, 1, 1};
    localparam int VF  [3] = '{750, 1125, 1111};
    localparam int VS  [3] = '{720, 1080, 1080};
    localparam int VSS [3] = '{725, 1084, 1097};
    localparam int VSE [3] = '{730, 1089, 1105};
    localparam int VP  [3] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [1:0]  mode_sel;
    logic [11:0] hcnt, vcnt;
    logic        de, de_early, hsync, vsync, sof, eol, mode_err;
    logic [1:0]  mode_act;

    hdmi_timing_gen #(
        .NUM_MODES    (3),
        .DEFAULT_MODE (0),
        .CNT_W        (12),
        .LOOKAHEAD    (LA),
        .VS_ALIGN_HS  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode_sel (mode_sel),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .de       (de),
        .de_early (de_early),
        .hsync    (hsync),
        .vsync    (vsync),
        .sof      (sof),
        .eol      (eol),
        .mode_act (mode_act),
        .mode_err (mode_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        de;
        logic        dee;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        eol;
        logic [1:0]  act;
        logic        err;
    } obs_t;

    typedef struct {
        bit    chk;
        string tag;
        obs_t  o;
    } exp_t;

    exp_t        sb[$];
    obs_t        last_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_h, m_v, m_act, m_pend;
    bit          m_err;
    string       phase = "reset";
    logic [11:0] jump_h, jump_v;

    function automatic obs_t reset_obs();
        obs_t o;
        o = '{h: 12'd1649, v: 12'd749, de: 1'b0, dee: 1'b0, hs: 1'b0, vs: 1'b0,
              sof: 1'b0, eol: 1'b0, act: 2'd0, err: 1'b0};
        return o;
    endfunction

    // vsync window expressed as a linear pixel index so edges land at x=HSYNC_START.
    function automatic obs_t model_obs(input int h, input int v, input int act,
                                       input int pend, input bit err);
        obs_t o;
        int   p, ph, pv, pa;
        bit   hs_on, vs_on;
        o.h   = 12'(h);
        o.v   = 12'(v);
        o.de  = (h < HS[act]) && (v < VS[act]);
        hs_on = (h >= HSS[act]) && (h < HSE[act]);
        o.hs  = (HP[act] != 0) ? hs_on : !hs_on;
        p     = v * HF[act] + h;
        vs_on = (p >= VSS[act] * HF[act] + HSS[act]) && (p < VSE[act] * HF[act] + HSS[act]);
        o.vs  = (VP[act] != 0) ? vs_on : !vs_on;
        o.sof = (h == 0) && (v == 0);
        o.eol = (h == HS[act] - 1) && (v < VS[act]);
        ph = h; pv = v; pa = act;
        for (int i = 0; i < LA; i++) begin
            ph++;
            if (ph == HF[pa]) begin
                ph = 0;
                pv++;
                if (pv == VF[pa]) begin
                    pv = 0;
                    pa = pend;
                end
            end
        end
        o.dee = (ph < HS[pa]) && (pv < VS[pa]);
        o.act = 2'(act);
        o.err = err;
        return o;
    endfunction

    task automatic model_reset();
        m_h = 1649; m_v = 749; m_act = 0; m_pend = 0; m_err = 1'b0;
    endtask

    task automatic model_step(input int sel);
        if (m_h == HF[m_act] - 1) begin
            m_h = 0;
            if (m_v == VF[m_act] - 1) begin
                m_v   = 0;
                m_act = m_pend;
            end else begin
                m_v++;
            end
        end else begin
            m_h++;
        end
        if (sel < 3) m_pend = sel;
        else         m_err  = 1'b1;
    endtask

    task automatic push_exp(input bit chk, input obs_t o);
        exp_t x;
        x.chk = chk;
        x.tag = phase;
        x.o   = o;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input bit r, input bit e, input int sel);
        obs_t o;
        @(negedge clk);
        rst_n    = r;
        en       = e;
        mode_sel = 2'(sel);
        if (!r) begin
            model_reset();
            o = reset_obs();
        end else if (e) begin
            model_step(sel);
            o = model_obs(m_h, m_v, m_act, m_pend, m_err);
        end else begin
            o = last_exp;
        end
        last_exp = o;
        push_exp(1'b1, o);
    endtask

    // Short pulse between rising edges: only an asynchronous reset can take effect.
    task automatic resetPulse();
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        last_exp = reset_obs();
        push_exp(1'b1, last_exp);
    endtask

    // Relocates the counters to skip long stretches of a frame; the following edge is not checked.
    task automatic jumpTo(input int h, input int v);
        @(negedge clk);
        en     = 1'b0;
        jump_h = 12'(h);
        jump_v = 12'(v);
        force dut.hcnt = jump_h;
        force dut.vcnt = jump_v;
        #1;
        release dut.hcnt;
        release dut.vcnt;
        m_h = h;
        m_v = v;
        push_exp(1'b0, last_exp);
    endtask

    task automatic checkOutput(input exp_t x);
        obs_t a;
        a = '{h: hcnt, v: vcnt, de: de, dee: de_early, hs: hsync, vs: vsync,
              sof: sof, eol: eol, act: mode_act, err: mode_err};
        n_checks++;
        if (a !== x.o) begin
            n_fail++;
            $display("[TB] FAIL %s t=%0t got h=%0d v=%0d de=%b dee=%b hs=%b vs=%b sof=%b eol=%b act=%0d err=%b, want h=%0d v=%0d de=%b dee=%b hs=%b vs=%b sof=%b eol=%b act=%0d err=%b",
                     x.tag, $time, a.h, a.v, a.de, a.dee, a.hs, a.vs, a.sof, a.eol, a.act, a.err,
                     x.o.h, x.o.v, x.o.de, x.o.dee, x.o.hs, x.o.vs, x.o.sof, x.o.eol, x.o.act, x.o.err);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL scoreboard_empty t=%0t got 0 entries, want 1", $time);
            end else begin
                x = sb.pop_front();
                if (x.chk) checkOutput(x);
            end
        end
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        en       = 1'b0;
        mode_sel = 2'd0;
        model_reset();
        last_exp = reset_obs();
        push_exp(1'b1, last_exp);
        repeat (3) applyStimulus(1'b0, 1'b0, 0);

        phase = "720p_lines";
        repeat (3400) applyStimulus(1'b1, 1'b1, 0);

        phase = "en_toggle";
        repeat (2000) applyStimulus(1'b1, ($urandom_range(99) >= 30), 0);

        phase = "mode_err";
        repeat (50) applyStimulus(1'b1, 1'b1, 3);

        phase = "switch_0_2";
        repeat (20) applyStimulus(1'b1, 1'b1, 2);
        jumpTo(1630, 749);
        repeat (80) applyStimulus(1'b1, 1'b1, 2);

        phase = "rb_vsync_on";
        jumpTo(1900, 1096);
        repeat (2100) applyStimulus(1'b1, 1'b1, 2);

        phase = "rb_vsync_off";
        jumpTo(1900, 1104);
        repeat (2100) applyStimulus(1'b1, 1'b1, 2);

        phase = "switch_2_1";
        repeat (10) applyStimulus(1'b1, 1'b1, 3);
        repeat (10) applyStimulus(1'b1, 1'b1, 1);
        jumpTo(1990, 1110);
        repeat (60) applyStimulus(1'b1, 1'b1, 1);

        phase = "1080p30_hsync";
        jumpTo(1990, 5);
        repeat (100) applyStimulus(1'b1, 1'b1, 1);

        phase = "switch_1_0";
        jumpTo(2190, 1124);
        repeat (30) applyStimulus(1'b1, 1'b1, 0);

        phase = "720p_vsync_on";
        jumpTo(1380, 724);
        repeat (1700) applyStimulus(1'b1, 1'b1, 0);

        phase = "720p_vsync_off";
        jumpTo(1380, 729);
        repeat (1700) applyStimulus(1'b1, 1'b1, 0);

        phase = "reset_pulse";
        jumpTo(490, 300);
        repeat (10) applyStimulus(1'b1, 1'b1, 0);
        resetPulse();
        repeat (20) applyStimulus(1'b1, 1'b1, 0);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
